sdram_wr_burst_ctrl: RTL and testbench
======================================

Name: sdram_wr_burst_ctrl

Overview:
Write-path stage directly downstream of the async fifo's read port. It drains the fifo in fixed-length bursts and presents each burst to the SDRAM controller's write port as a request/grant handshake plus a paced data stream. It also generates the burst start address, stepping linearly through a ring region. Runs entirely in the SDRAM (fifo read) clock domain.

Parameters:
DATA_WIDTH, 16, width of fifo and SDRAM data words
ADDR_WIDTH, 24, SDRAM word address width
USE_WIDTH, 10, width of fifo read-side fill count
BURST_LEN, 8, words per burst; power of two, 1..256
ADDR_BASE, 24'h000000, first burst address of ring region
ADDR_END, 24'h00FFFF, last word address of ring region (inclusive); (ADDR_END-ADDR_BASE+1) is a multiple of BURST_LEN

Ports:
i_clk  in  1  clock (shared with fifo read side)
i_rst  in  1  synchronous reset, active-high
i_en  in  1  allow new bursts to start
i_addr_clr  in  1  restart address at ADDR_BASE
i_fifo_rd_use  in  USE_WIDTH  fifo read-side fill count
i_fifo_rd_empty  in  1  fifo empty
o_fifo_rd_en  out  1  fifo read strobe
i_fifo_rd_data  in  DATA_WIDTH  fifo read data, valid 1 cycle after o_fifo_rd_en
o_wr_req  out  1  burst write request to SDRAM controller
o_wr_addr  out  ADDR_WIDTH  burst start address, stable while o_wr_req=1
i_wr_grant  in  1  controller accepts the request (1-cycle pulse)
i_wr_data_req  in  1  controller asks for the next word
o_wr_data  out  DATA_WIDTH  write data to controller
o_wr_data_vld  out  1  o_wr_data valid this cycle
o_burst_done  out  1  1-cycle pulse at end of each burst
o_busy  out  1  state != IDLE
o_underrun  out  1  sticky: word requested while fifo empty

Behaviour:
- Reset (i_rst=1 at posedge): state=IDLE, word count=0, addr=ADDR_BASE, pending clear=0. Registered outputs go to 0 (o_wr_req, o_wr_data_vld, o_burst_done, o_underrun). o_wr_addr shows ADDR_BASE.
- Reset mid-burst aborts immediately. Any words already read from the fifo are lost. No o_burst_done pulse.
- FSM states: IDLE, REQ, DATA, DONE.
- IDLE -> REQ when i_en=1 and i_fifo_rd_use >= BURST_LEN. o_wr_req rises on the next cycle.
- REQ: o_wr_req held at 1 until i_wr_grant=1 is sampled. Then -> DATA, and o_wr_req is 0 from the next cycle. If i_wr_grant=1 is seen in IDLE or DATA, it is ignored.
- DATA: o_fifo_rd_en = i_wr_data_req AND (cnt < BURST_LEN). This is combinational, so the fifo read is issued in the same cycle as the request.
  - cnt increments on each o_fifo_rd_en.
  - o_wr_data_vld is o_fifo_rd_en delayed by 1 cycle. o_wr_data = i_fifo_rd_data, unregistered, aligned with o_wr_data_vld.
  - Controller-side latency: a request in cycle N gives data valid in cycle N+1.
  - Gaps in i_wr_data_req are allowed; the block simply waits.
  - i_wr_data_req after cnt == BURST_LEN is ignored: no read, no vld.
  - DATA -> DONE in the cycle after the BURST_LEN-th read, i.e. together with the last o_wr_data_vld.
- DONE (exactly 1 cycle):
  - o_burst_done=1.
  - cnt <- 0.
  - addr <- addr + BURST_LEN. If addr+BURST_LEN > ADDR_END, addr <- ADDR_BASE instead (wrap).
  - If the pending clear flag is set, addr <- ADDR_BASE and the flag is cleared.
  - Then -> IDLE.
- Minimum gap: 1 IDLE cycle between o_burst_done and the next o_wr_req.
- i_addr_clr:
  - In IDLE it sets addr=ADDR_BASE on the next cycle. It takes priority over starting a burst in that cycle.
  - In REQ, DATA or DONE it sets the pending flag and does not disturb the current o_wr_addr.
- i_en deasserted during REQ or DATA: the current burst completes normally; no new burst starts.
- Underrun: o_fifo_rd_en=1 while i_fifo_rd_empty=1 sets o_underrun. It is cleared only by reset. The data word is still counted.
- Width rules: the use-count comparison is unsigned at USE_WIDTH. The address add is done at ADDR_WIDTH+1 bits to detect wrap without overflow. cnt is clog2(BURST_LEN)+1 bits.

Decomposition:
- Shared package/header: FSM state encoding (IDLE=0, REQ=1, DATA=2, DONE=3) and the address-wrap helper constant (ADDR_END-BURST_LEN+1, the last legal burst start).
- One natural sub-module: sdram_burst_addr_gen. It holds the ring address register and handles step, wrap and clear, with pending-clear logic; it can be reused later by the read-path controller.

Test Plan:
- Fill fifo with 8 words 0x01..0x08 (BURST_LEN=8, i_en=1) and grant 2 cycles after o_wr_req -> o_wr_addr=0x000000; 8 o_wr_data_vld beats carry 0x01..0x08 in order; o_burst_done pulses once; next o_wr_addr=0x000008.
- Fifo holds 7 words -> o_wr_req stays 0; on the 8th write, the request rises within 2 cycles.
- i_wr_data_req toggles 1,0,0,1,... plus 3 extra requests after the 8th word -> exactly 8 o_fifo_rd_en and 8 vld beats, each vld one cycle after its read, no extra reads.
- ADDR_END=0x1F, run 5 bursts -> addresses 0x00, 0x08, 0x10, 0x18, 0x00.
- i_addr_clr pulsed in DATA of the burst at 0x10 -> that burst still writes at 0x10; next o_wr_addr=0x00. i_rst asserted mid-DATA -> o_wr_req=0, o_busy=0, no o_burst_done, address 0x00.
- i_wr_data_req with fifo empty (forced use count) -> o_underrun=1 and it stays set until i_rst.

Source files
------------

// File: rtl/sdram_wr_burst_ctrl_pkg.sv
// sdram_wr_burst_ctrl_pkg: shared FSM encoding and ring-address helper for the SDRAM burst path
package sdram_wr_burst_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;
  function automatic longint unsigned last_burst_start(input longint unsigned addr_end, input longint unsigned burst_len);
    return addr_end - burst_len + 1;
  endfunction
endpackage

// File: rtl/sdram_burst_addr_gen.sv
// sdram_burst_addr_gen: ring burst-start address with step, wrap, immediate clear and deferred clear
module sdram_burst_addr_gen
  import sdram_wr_burst_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int BURST_LEN = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = 24'h000000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_END = 24'h00FFFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_idle,
  input  logic                  i_step,
  input  logic                  i_clr,
  output logic [ADDR_WIDTH-1:0] o_addr
);
  localparam logic [ADDR_WIDTH:0] LAST_START = (ADDR_WIDTH+1)'(last_burst_start(64'(ADDR_END), 64'(BURST_LEN)));
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_pend;
  logic [ADDR_WIDTH:0]   w_sum;
  logic                  w_wrap;
  assign w_sum  = {1'b0, r_addr} + (ADDR_WIDTH+1)'(BURST_LEN);
  assign w_wrap = w_sum[ADDR_WIDTH] | ({1'b0, r_addr} >= LAST_START);
  assign o_addr = r_addr;
  // a clear outside IDLE is deferred so the address of the burst in flight stays put
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr <= ADDR_BASE;
      r_pend <= 1'b0;
    end else if (i_step) begin
      r_addr <= (r_pend | i_clr | w_wrap) ? ADDR_BASE : w_sum[ADDR_WIDTH-1:0];
      r_pend <= 1'b0;
    end else if (i_clr) begin
      r_addr <= i_idle ? ADDR_BASE : r_addr;
      r_pend <= !i_idle;
    end
  end
endmodule

// File: rtl/sdram_wr_burst_ctrl.sv
// sdram_wr_burst_ctrl: drains the fifo in fixed bursts into the SDRAM controller write port
module sdram_wr_burst_ctrl
  import sdram_wr_burst_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 24,
  parameter int USE_WIDTH = 10,
  parameter int BURST_LEN = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = 24'h000000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_END = 24'h00FFFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_addr_clr,
  input  logic [USE_WIDTH-1:0]  i_fifo_rd_use,
  input  logic                  i_fifo_rd_empty,
  output logic                  o_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  output logic                  o_wr_req,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  input  logic                  i_wr_grant,
  input  logic                  i_wr_data_req,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_wr_data_vld,
  output logic                  o_burst_done,
  output logic                  o_busy,
  output logic                  o_underrun
);
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] BL = CW'(BURST_LEN);
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_wr_req, r_vld, r_done, r_underrun;
  logic          w_start, w_rd_en;
  assign w_start       = i_en && !i_addr_clr && (i_fifo_rd_use >= USE_WIDTH'(BURST_LEN));
  assign w_rd_en       = (r_state == DATA) && i_wr_data_req && (r_cnt < BL);
  assign o_fifo_rd_en  = w_rd_en;
  assign o_wr_req      = r_wr_req;
  assign o_wr_data     = i_fifo_rd_data;
  assign o_wr_data_vld = r_vld;
  assign o_burst_done  = r_done;
  assign o_busy        = r_state != IDLE;
  assign o_underrun    = r_underrun;
  // DONE is entered with the last read so o_burst_done lines up with the final data beat
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wr_req   <= 1'b0;
      r_vld      <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_vld      <= w_rd_en;
      r_underrun <= r_underrun | (w_rd_en & i_fifo_rd_empty);
      r_done     <= 1'b0;
      case (r_state)
        IDLE: if (w_start) begin
          r_state  <= REQ;
          r_wr_req <= 1'b1;
        end
        REQ: if (i_wr_grant) begin
          r_state  <= DATA;
          r_wr_req <= 1'b0;
        end
        DATA: if (w_rd_en) begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == BL - CW'(1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  sdram_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BURST_LEN (BURST_LEN),
    .ADDR_BASE (ADDR_BASE),
    .ADDR_END  (ADDR_END)
  ) u_addr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_idle(r_state == IDLE),
    .i_step(r_state == DONE),
    .i_clr (i_addr_clr),
    .o_addr(o_wr_addr)
  );
endmodule

// File: tb/tb_sdram_wr_burst_ctrl.sv
// tb_sdram_wr_burst_ctrl: directed tests of the SDRAM write burst controller against a small fifo model
module tb_sdram_wr_burst_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst = 1'b1, en = 1'b0, addr_clr = 1'b0, grant = 1'b0, data_req = 1'b0;
  logic        rd_en, wr_req, vld, done, busy, underrun;
  logic [9:0]  use_cnt;
  logic        empty;
  logic [15:0] rd_data, wr_data;
  logic [23:0] wr_addr;
  logic [15:0] mem [0:255];
  int          wr_ptr = 0, rd_ptr = 0;
  logic        flush = 1'b0, use_ovr = 1'b0, empty_val = 1'b0;
  logic [9:0]  use_val = '0;
  int          n_vec = 0, n_err = 0;

  assign use_cnt = use_ovr ? use_val : 10'(wr_ptr - rd_ptr);
  assign empty   = use_ovr ? empty_val : (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (rd_en === 1'b1 && rd_ptr != wr_ptr) begin
      rd_data <= mem[rd_ptr[7:0]];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  sdram_wr_burst_ctrl #(.ADDR_END(24'h00001F)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_addr_clr(addr_clr),
    .i_fifo_rd_use(use_cnt), .i_fifo_rd_empty(empty), .o_fifo_rd_en(rd_en),
    .i_fifo_rd_data(rd_data), .o_wr_req(wr_req), .o_wr_addr(wr_addr),
    .i_wr_grant(grant), .i_wr_data_req(data_req), .o_wr_data(wr_data),
    .o_wr_data_vld(vld), .o_burst_done(done), .o_busy(busy), .o_underrun(underrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr++;
  endtask

  task automatic do_burst(input logic [2:0] pat, input int plen, input logic [15:0] first, input int clr_at,
                          output logic [23:0] addr, output int n_rd, output int n_vld, output int n_done,
                          output int n_bad, output int n_mis, output bit to);
    int w, post;
    logic prev;
    n_rd = 0; n_vld = 0; n_done = 0; n_bad = 0; n_mis = 0; to = 0; w = 0; addr = '0;
    while (wr_req !== 1'b1 && w < 20) begin tick(); w++; end
    if (wr_req !== 1'b1) begin to = 1; return; end
    addr = wr_addr;
    tick(); tick();
    grant = 1'b1; tick(); grant = 1'b0;
    prev = 1'b0; post = -1;
    for (int i = 0; i < 80 && post != 0; i++) begin
      data_req = pat[i % plen];
      addr_clr = (i == clr_at);
      #1;
      if (vld !== prev) n_mis++;
      if (vld === 1'b1) begin
        if (wr_data !== first + 16'(n_vld)) n_bad++;
        n_vld++;
      end
      if (done === 1'b1) begin n_done++; if (post < 0) post = 4; end
      prev = rd_en;
      if (rd_en === 1'b1) n_rd++;
      if (post > 0) post--;
      tick();
    end
    data_req = 1'b0; addr_clr = 1'b0;
    if (post != 0) to = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_vec++; if (wr_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%0h exp=0", wr_req); end
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL rst_vld got=%0h exp=0", vld); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%0h exp=0", done); end
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL rst_underrun got=%0h exp=0", underrun); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    n_vec++; if (wr_addr !== 24'h0) begin n_err++; $display("FAIL rst_addr got=%h exp=000000", wr_addr); end
    rst = 1'b0; tick();
  endtask

  task automatic test_basic();
    logic [23:0] a; int nr, nv, nd, nb, nm; bit to;
    for (int i = 1; i <= 8; i++) push(16'(i));
    en = 1'b1;
    do_burst(3'b111, 3, 16'h0001, -1, a, nr, nv, nd, nb, nm, to);
    n_vec++; if (to) begin n_err++; $display("FAIL basic_timeout got=1 exp=0"); end
    n_vec++; if (a !== 24'h0) begin n_err++; $display("FAIL basic_addr got=%h exp=000000", a); end
    n_vec++; if (nr != 8 || nv != 8) begin n_err++; $display("FAIL basic_beats rd=%0d vld=%0d exp=8/8", nr, nv); end
    n_vec++; if (nb != 0) begin n_err++; $display("FAIL basic_data bad=%0d exp=0", nb); end
    n_vec++; if (nd != 1) begin n_err++; $display("FAIL basic_done got=%0d exp=1", nd); end
    n_vec++; if (nm != 0) begin n_err++; $display("FAIL basic_align got=%0d exp=0", nm); end
    tick();
    n_vec++; if (wr_addr !== 24'h8) begin n_err++; $display("FAIL basic_next_addr got=%h exp=000008", wr_addr); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle got=%0h exp=0", busy); end
  endtask

  task automatic test_threshold();
    logic [23:0] a; int nr, nv, nd, nb, nm, w; bit to;
    for (int i = 0; i < 7; i++) push(16'h11 + 16'(i));
    grant = 1'b1; tick(); grant = 1'b0; tick(); tick(); tick();
    n_vec++; if (wr_req !== 1'b0) begin n_err++; $display("FAIL thr_req7 got=%0h exp=0", wr_req); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL thr_busy7 got=%0h exp=0", busy); end
    push(16'h18);
    w = 0;
    while (wr_req !== 1'b1 && w < 2) begin tick(); w++; end
    n_vec++; if (wr_req !== 1'b1) begin n_err++; $display("FAIL thr_req8 got=%0h exp=1", wr_req); end
    do_burst(3'b001, 3, 16'h0011, -1, a, nr, nv, nd, nb, nm, to);
    n_vec++; if (to) begin n_err++; $display("FAIL thr_timeout got=1 exp=0"); end
    n_vec++; if (a !== 24'h8) begin n_err++; $display("FAIL thr_addr got=%h exp=000008", a); end
    n_vec++; if (nr != 8 || nv != 8) begin n_err++; $display("FAIL gap_beats rd=%0d vld=%0d exp=8/8", nr, nv); end
    n_vec++; if (nm != 0) begin n_err++; $display("FAIL gap_align got=%0d exp=0", nm); end
    n_vec++; if (nb != 0) begin n_err++; $display("FAIL gap_data bad=%0d exp=0", nb); end
  endtask

  task automatic test_reset_mid();
    int w;
    for (int i = 0; i < 8; i++) push(16'h21 + 16'(i));
    w = 0;
    while (wr_req !== 1'b1 && w < 20) begin tick(); w++; end
    n_vec++; if (wr_addr !== 24'h10) begin n_err++; $display("FAIL mid_addr got=%h exp=000010", wr_addr); end
    tick(); grant = 1'b1; tick(); grant = 1'b0;
    data_req = 1'b1; tick(); tick(); tick();
    rst = 1'b1; data_req = 1'b0; en = 1'b0; tick();
    n_vec++; if (wr_req !== 1'b0) begin n_err++; $display("FAIL mid_req got=%0h exp=0", wr_req); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got=%0h exp=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_done got=%0h exp=0", done); end
    n_vec++; if (wr_addr !== 24'h0) begin n_err++; $display("FAIL mid_addr_rst got=%h exp=000000", wr_addr); end
    rst = 1'b0; flush = 1'b1; tick(); flush = 1'b0; tick();
  endtask

  task automatic test_wrap();
    logic [23:0] a; int nr, nv, nd, nb, nm; bit to;
    logic [23:0] exp_a [5];
    exp_a = '{24'h0, 24'h8, 24'h10, 24'h18, 24'h0};
    for (int i = 0; i < 40; i++) push(16'h40 + 16'(i));
    en = 1'b1;
    for (int b = 0; b < 5; b++) begin
      do_burst(3'b111, 3, 16'h40 + 16'(8 * b), -1, a, nr, nv, nd, nb, nm, to);
      n_vec++; if (to || a !== exp_a[b]) begin n_err++; $display("FAIL wrap_addr%0d got=%h exp=%h to=%0d", b, a, exp_a[b], to); end
      n_vec++; if (nb != 0 || nv != 8) begin n_err++; $display("FAIL wrap_data%0d bad=%0d vld=%0d exp=0/8", b, nb, nv); end
    end
  endtask

  task automatic test_addr_clr();
    logic [23:0] a; int nr, nv, nd, nb, nm; bit to;
    for (int i = 0; i < 24; i++) push(16'h80 + 16'(i));
    do_burst(3'b111, 3, 16'h80, -1, a, nr, nv, nd, nb, nm, to);
    n_vec++; if (to || a !== 24'h8) begin n_err++; $display("FAIL clr_addr0 got=%h exp=000008", a); end
    do_burst(3'b111, 3, 16'h88, 2, a, nr, nv, nd, nb, nm, to);
    n_vec++; if (to || a !== 24'h10) begin n_err++; $display("FAIL clr_addr1 got=%h exp=000010", a); end
    n_vec++; if (nd != 1 || nb != 0) begin n_err++; $display("FAIL clr_burst done=%0d bad=%0d exp=1/0", nd, nb); end
    do_burst(3'b111, 3, 16'h90, -1, a, nr, nv, nd, nb, nm, to);
    n_vec++; if (to || a !== 24'h0) begin n_err++; $display("FAIL clr_addr2 got=%h exp=000000", a); end
    en = 1'b0; tick();
    n_vec++; if (wr_addr !== 24'h8) begin n_err++; $display("FAIL clr_pre_idle got=%h exp=000008", wr_addr); end
    addr_clr = 1'b1; tick(); addr_clr = 1'b0;
    n_vec++; if (wr_addr !== 24'h0) begin n_err++; $display("FAIL clr_idle got=%h exp=000000", wr_addr); end
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL no_underrun got=%0h exp=0", underrun); end
  endtask

  task automatic test_underrun();
    logic [23:0] a; int nr, nv, nd, nb, nm; bit to;
    use_ovr = 1'b1; use_val = 10'd8; empty_val = 1'b1; en = 1'b1;
    do_burst(3'b111, 3, 16'h0, -1, a, nr, nv, nd, nb, nm, to);
    en = 1'b0;
    n_vec++; if (to || nr != 8 || nd != 1) begin n_err++; $display("FAIL ur_count rd=%0d done=%0d exp=8/1", nr, nd); end
    n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL ur_set got=%0h exp=1", underrun); end
    use_ovr = 1'b0; tick(); tick(); tick();
    n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL ur_sticky got=%0h exp=1", underrun); end
    rst = 1'b1; tick(); rst = 1'b0; tick();
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL ur_clear got=%0h exp=0", underrun); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_threshold();
    test_reset_mid();
    test_wrap();
    test_addr_clr();
    test_underrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
